axi_chan_buffer: RTL and testbench
==================================

// Module: axi_chan_buffer
// PURPOSE
//  Parametrised valid/ready buffer for any single AXI/APB-style channel (A, W, R, B payloads).
//  Generalises the per-channel handshake into a DEPTH-entry elastic buffer with optional
//  store-and-forward on LAST. Sits between a channel source and destination in the controller
//  datapath (e.g. AXI W into the write-data path) to break timing and absorb bursts.
// PARAMETERS
//  DATA_WIDTH  64  payload bits per beat (caller packs id/addr/strb/resp as needed)
//  DEPTH       4   entries; power of two, >= 2
//  SAF         0   0 = cut-through; 1 = store-and-forward (release only complete LAST-terminated bursts)
// PORTS
//  clk         in   1                     single clock, all logic posedge
//  rst         in   1                     asynchronous reset, active-high
//  s_valid     in   1                     source beat valid
//  s_ready     out  1                     buffer can accept a beat
//  s_data      in   DATA_WIDTH            source payload
//  s_last      in   1                     last beat of burst (tie 1 for single-beat channels)
//  m_valid     out  1                     buffer presents a beat
//  m_ready     in   1                     destination accepts
//  m_data      out  DATA_WIDTH            head payload
//  m_last      out  1                     head LAST flag
//  occupancy   out  $clog2(DEPTH+1)       entries held
//  pkt_count   out  $clog2(DEPTH+1)       LAST-terminated bursts held
// BEHAVIOUR
//  - Reset (async, rst=1): pointers, occupancy, pkt_count = 0; m_valid=0; s_ready=0 while rst high,
//    s_ready=1 from the first clk edge after rst deasserts. Contents discarded; m_data/m_last undefined.
//  - Reset mid-burst: all stored beats dropped, no partial output after release.
//  - Push = s_valid & s_ready; pop = m_valid & m_ready; both evaluated on the same clk edge.
//  - s_ready = registered !full; no combinational path m_ready->s_ready or s_*->m_*.
//  - Latency: beat pushed at edge N is visible on m_valid/m_data after edge N (cycle N+1), cut-through.
//  - m_valid: SAF=0 -> occupancy!=0. SAF=1 -> pkt_count!=0 OR occupancy==DEPTH (anti-deadlock: a
//    burst longer than DEPTH drains in cut-through fashion once full).
//  - m_data/m_last driven from storage at read pointer; stable while m_valid & !m_ready.
//  - Full: s_ready=0, push blocked even if pop occurs that cycle; s_ready returns 1 the next cycle.
//  - Empty: pop impossible; simultaneous push while empty just fills.
//  - Push & pop same edge (not full, not empty): occupancy unchanged, both pointers advance.
//  - pkt_count: +1 on push with s_last, -1 on pop with m_last, unchanged if both.
//  - Pointers $clog2(DEPTH) bits, natural wrap at DEPTH; full/empty from occupancy counter.
//  - Source holding s_valid with changing data while !s_ready is not sampled (AXI rule on source).
// STRUCTURE
//  - Package axi_buf_pkg: localparam helpers (PTR_W, CNT_W functions), typedef struct packed
//    {logic last; logic [DATA_WIDTH-1:0] data;} beat template, SAF mode enum.
//  - One sub-module axi_buf_core: register-array storage + wr/rd pointers + occupancy/full.
//    Top adds pkt_count, SAF release logic and reset-gated s_ready.
// TESTING
//  1 Reset: hold rst 3 cycles -> s_ready=0, m_valid=0, occupancy=0; release -> s_ready=1 next edge.
//  2 DEPTH=4, SAF=0, m_ready=0, push 0xA0..0xA4 -> 4 accepted, s_ready=0 at occupancy 4, 0xA4 held;
//    then m_ready=1 -> outputs 0xA0,0xA1,0xA2,0xA3,0xA4 in order, no loss/dup.
//  3 Full + simultaneous pop: occupancy 4, s_valid=1, m_ready=1 -> no push that edge, occupancy 3,
//    push lands next edge -> occupancy 3 steady under continuous traffic thereafter.
//  4 SAF=1: push 3 beats, last on beat 3 -> m_valid stays 0 until the edge after beat 3, pkt_count=1;
//    pop all -> pkt_count=0, m_last=1 on third beat only.
//  5 SAF=1 burst of 6 beats into DEPTH=4 -> m_valid asserts at occupancy 4, all 6 beats delivered.
//  6 Reset mid-burst: 2 beats stored, pulse rst 1 cycle -> occupancy=0, m_valid=0, no stale beat out.

Source files
------------

// File: rtl/axi_chan_buffer_pkg.sv
// Shared definitions for the elastic channel buffer: width helpers,
// the beat layout template and the release-mode encoding.
package axi_buf_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_DEPTH      = 4;

    // Release policy of the buffer head.
    typedef enum logic {
        SAF_CUT_THROUGH = 1'b0,
        SAF_STORE_FWD   = 1'b1
    } saf_mode_e;

    // One stored beat at the default payload width; modules with another
    // width declare the same layout locally.
    typedef struct packed {
        logic                          last;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } beat_t;

    // Pointer width for a DEPTH-entry ring (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter width able to hold the values 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axi_chan_buffer_if.sv
// Single valid/ready channel bundle (payload + LAST) with source and sink views.
interface axi_chan_buffer_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;

    // Side that drives the beat.
    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    // Side that receives the beat.
    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/axi_chan_buffer_core.sv
// Ring-buffer core: register-array storage, read/write pointers and an
// occupancy counter from which full/empty are derived. Requests that would
// overflow or underflow are ignored here as a second line of defence.
module axi_buf_core
    import axi_buf_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int DEPTH      = 4,
    localparam int PTR_W      = ptr_w(DEPTH),
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH:0]   wr_beat,
    output logic [DATA_WIDTH:0]   rd_beat,
    output logic [CNT_W-1:0]      occupancy,
    output logic                  full,
    output logic                  empty,
    output logic                  full_next
);

    logic [DATA_WIDTH:0] mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    occ_r;
    logic [CNT_W-1:0]    occ_next_s;
    logic                push_ok_s;
    logic                pop_ok_s;

    assign full      = (occ_r == CNT_W'(DEPTH));
    assign empty     = (occ_r == CNT_W'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign occupancy = occ_r;
    assign rd_beat   = mem_r[rd_ptr_r];
    assign full_next = (occ_next_s == CNT_W'(DEPTH));

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        occ_next_s = occ_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   occ_next_s = occ_r + CNT_W'(1);
            2'b01:   occ_next_s = occ_r - CNT_W'(1);
            default: occ_next_s = occ_r;
        endcase
    end

    // Payload storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_beat;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks the fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            occ_r    <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            occ_r <= occ_next_s;
        end
    end

endmodule

// File: rtl/axi_chan_buffer.sv
// Elastic valid/ready channel buffer. Wraps the ring core with a registered
// s_ready, a count of complete (LAST-terminated) bursts and the head release
// policy: cut-through, or store-and-forward with a full-buffer escape so a
// burst longer than DEPTH can still drain.
module axi_chan_buffer
    import axi_buf_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int DEPTH      = 4,
    parameter  int SAF        = 0,
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    axi_chan_buffer_if.slave   s_if,
    axi_chan_buffer_if.master  m_if,
    output logic [CNT_W-1:0]   occupancy,
    output logic [CNT_W-1:0]   pkt_count
);

    localparam saf_mode_e MODE = (SAF != 0) ? SAF_STORE_FWD : SAF_CUT_THROUGH;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } chan_beat_t;

    chan_beat_t       wr_beat_s;
    chan_beat_t       rd_beat_s;
    logic [CNT_W-1:0] occ_s;
    logic             full_s;
    logic             empty_s;
    logic             full_next_s;
    logic             s_ready_r;
    logic [CNT_W-1:0] pkt_r;
    logic [CNT_W-1:0] pkt_next_s;
    logic             m_valid_s;
    logic             push_s;
    logic             pop_s;
    logic             push_last_s;
    logic             pop_last_s;

    assign wr_beat_s.last = s_if.last;
    assign wr_beat_s.data = s_if.data;

    assign push_s      = s_if.valid & s_ready_r;
    assign pop_s       = m_valid_s & m_if.ready;
    assign push_last_s = push_s & s_if.last;
    assign pop_last_s  = pop_s & rd_beat_s.last;

    axi_buf_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .pop        (pop_s),
        .wr_beat    (wr_beat_s),
        .rd_beat    (rd_beat_s),
        .occupancy  (occ_s),
        .full       (full_s),
        .empty      (empty_s),
        .full_next  (full_next_s)
    );

    // s_ready is low through reset and then mirrors "not full" one edge late,
    // so a pop never frees a slot for a push on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready_r <= 1'b0;
        end else begin
            s_ready_r <= ~full_next_s;
        end
    end

    // Complete-burst count: LAST in adds one, LAST out removes one.
    always_comb begin
        pkt_next_s = pkt_r;
        case ({push_last_s, pop_last_s})
            2'b10:   pkt_next_s = pkt_r + CNT_W'(1);
            2'b01:   pkt_next_s = pkt_r - CNT_W'(1);
            default: pkt_next_s = pkt_r;
        endcase
    end

    // Burst counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_r <= CNT_W'(0);
        end else begin
            pkt_r <= pkt_next_s;
        end
    end

    // Head release: any beat in cut-through; a whole burst (or a full
    // buffer, to avoid deadlock on oversize bursts) in store-and-forward.
    always_comb begin
        m_valid_s = 1'b0;
        if (MODE == SAF_STORE_FWD) begin
            m_valid_s = (pkt_r != CNT_W'(0)) | full_s;
        end else begin
            m_valid_s = ~empty_s;
        end
    end

    assign s_if.ready = s_ready_r;
    assign m_if.valid = m_valid_s;
    assign m_if.data  = rd_beat_s.data;
    assign m_if.last  = rd_beat_s.last;
    assign occupancy  = occ_s;
    assign pkt_count  = pkt_r;

endmodule

// File: tb/tb_axi_chan_buffer.sv
// Self-checking bench for axi_chan_buffer: one cut-through and one
// store-and-forward instance, checked every cycle against a queue model.
module tb_axi_chan_buffer;
    import axi_buf_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] occ0, pkt0, occ1, pkt1;

    always #5 clk = ~clk;

    axi_chan_buffer_if #(.DATA_WIDTH(DW)) s_if0 ();
    axi_chan_buffer_if #(.DATA_WIDTH(DW)) m_if0 ();
    axi_chan_buffer_if #(.DATA_WIDTH(DW)) s_if1 ();
    axi_chan_buffer_if #(.DATA_WIDTH(DW)) m_if1 ();

    axi_chan_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SAF(0)) dut0 (
        .clk(clk), .rst(rst), .s_if(s_if0), .m_if(m_if0),
        .occupancy(occ0), .pkt_count(pkt0)
    );

    axi_chan_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SAF(1)) dut1 (
        .clk(clk), .rst(rst), .s_if(s_if1), .m_if(m_if1),
        .occupancy(occ1), .pkt_count(pkt1)
    );

    // Reference model: queue of held beats plus the expected s_ready.
    beat_t mq[$];
    bit    cur_saf;
    bit    exp_ready;
    int    checks = 0;
    int    errors = 0;

    function automatic int lasts_in_q();
        int n = 0;
        foreach (mq[i]) if (mq[i].last) n++;
        return n;
    endfunction

    function automatic bit exp_mvalid();
        if (cur_saf) return (lasts_in_q() != 0) || (mq.size() == DEPTH);
        return mq.size() != 0;
    endfunction

    task automatic drive(input bit sv, input logic [DW-1:0] sd, input bit sl, input bit mr);
        s_if0.valid = cur_saf ? 1'b0 : sv;  s_if0.data = sd; s_if0.last = sl;
        m_if0.ready = cur_saf ? 1'b0 : mr;
        s_if1.valid = cur_saf ? sv : 1'b0;  s_if1.data = sd; s_if1.last = sl;
        m_if1.ready = cur_saf ? mr : 1'b0;
    endtask

    task automatic read_outs(output logic sr, output logic mv, output logic [DW-1:0] md,
                             output logic ml, output logic [2:0] oc, output logic [2:0] pc);
        if (cur_saf) begin
            sr = s_if1.ready; mv = m_if1.valid; md = m_if1.data; ml = m_if1.last; oc = occ1; pc = pkt1;
        end else begin
            sr = s_if0.ready; mv = m_if0.valid; md = m_if0.data; ml = m_if0.last; oc = occ0; pc = pkt0;
        end
    endtask

    // Compare the active instance against the model; called mid-cycle.
    task automatic check_outs(input string tag);
        logic sr, mv, ml; logic [DW-1:0] md; logic [2:0] oc, pc;
        bit   emv;
        read_outs(sr, mv, md, ml, oc, pc);
        emv = exp_mvalid();
        checks++;
        if (sr !== exp_ready) begin errors++; $display("FAIL %s s_ready: got %0b want %0b", tag, sr, exp_ready); end
        checks++;
        if (mv !== emv) begin errors++; $display("FAIL %s m_valid: got %0b want %0b", tag, mv, emv); end
        checks++;
        if (int'(oc) != mq.size()) begin errors++; $display("FAIL %s occupancy: got %0d want %0d", tag, oc, mq.size()); end
        checks++;
        if (int'(pc) != lasts_in_q()) begin errors++; $display("FAIL %s pkt_count: got %0d want %0d", tag, pc, lasts_in_q()); end
        if (emv) begin
            checks++;
            if (md !== mq[0].data || ml !== mq[0].last) begin
                errors++;
                $display("FAIL %s head: got %h/%0b want %h/%0b", tag, md, ml, mq[0].data, mq[0].last);
            end
        end
    endtask

    // One clock: drive at negedge, check, advance model on posedge.
    task automatic cycle(input bit sv, input logic [DW-1:0] sd, input bit sl, input bit mr,
                         output bit pushed, output bit popped, output beat_t got);
        logic sr, mv, ml; logic [DW-1:0] md; logic [2:0] oc, pc;
        bit   emv;
        drive(sv, sd, sl, mr);
        #1;
        check_outs(cur_saf ? "saf1" : "saf0");
        read_outs(sr, mv, md, ml, oc, pc);
        emv    = exp_mvalid();
        pushed = sv & exp_ready;
        popped = emv & mr;
        got.data = md;
        got.last = ml;
        @(posedge clk);
        if (popped) void'(mq.pop_front());
        if (pushed) mq.push_back('{last: sl, data: sd});
        exp_ready = (mq.size() != DEPTH);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        mq.delete();
        exp_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if (s_if0.ready !== 1'b0 || s_if1.ready !== 1'b0) begin
                errors++; $display("FAIL rst s_ready: got %0b/%0b want 0", s_if0.ready, s_if1.ready);
            end
            checks++;
            if (m_if0.valid !== 1'b0 || m_if1.valid !== 1'b0) begin
                errors++; $display("FAIL rst m_valid: got %0b/%0b want 0", m_if0.valid, m_if1.valid);
            end
            checks++;
            if (occ0 !== 3'd0 || occ1 !== 3'd0 || pkt0 !== 3'd0 || pkt1 !== 3'd0) begin
                errors++; $display("FAIL rst counters: got occ %0d/%0d pkt %0d/%0d want 0", occ0, occ1, pkt0, pkt1);
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    // Push a list of beats and drain; collects what the DUT delivered.
    task automatic run_stream(input beat_t beats[$], input int mode, output beat_t got[$]);
        int idx = 0; int guard = 0;
        bit p, q, sv, mr; beat_t b;
        got = {};
        while ((idx < beats.size() || mq.size() != 0) && guard < 3000) begin
            mr = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            sv = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (idx < beats.size()) cycle(sv, beats[idx].data, beats[idx].last, mr, p, q, b);
            else                    cycle(1'b0, '0, 1'b0, mr, p, q, b);
            if (p) idx++;
            if (q) got.push_back(b);
            guard++;
        end
        checks++;
        if (guard >= 3000) begin errors++; $display("FAIL stream_timeout: got %0d beats out want %0d", got.size(), beats.size()); end
        checks++;
        if (got.size() != beats.size()) begin
            errors++; $display("FAIL stream_count: got %0d want %0d", got.size(), beats.size());
        end else begin
            foreach (beats[i]) begin
                checks++;
                if (got[i] !== beats[i]) begin
                    errors++; $display("FAIL stream_order[%0d]: got %h want %h", i, got[i], beats[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        bit p, q; beat_t b;
        cur_saf = 1'b0;
        do_reset(3);
        cycle(1'b0, '0, 1'b0, 1'b0, p, q, b);   // s_ready still 0 before first edge
        cycle(1'b0, '0, 1'b0, 1'b0, p, q, b);   // s_ready now 1
        checks++;
        if (s_if0.ready !== 1'b1 || s_if1.ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: got %0b/%0b want 1", s_if0.ready, s_if1.ready);
        end
    endtask

    task automatic test_fill_drain();
        bit p, q; beat_t b; beat_t got[$]; int k = 0; int guard = 0;
        cur_saf = 1'b0;
        do_reset(1);
        while (k < 5 && guard < 12) begin
            cycle(1'b1, 64'hA0 + 64'(k), 1'b1, 1'b0, p, q, b);
            if (p) k++;
            guard++;
        end
        checks++;
        if (k != 4 || occ0 !== 3'd4 || s_if0.ready !== 1'b0) begin
            errors++; $display("FAIL fill: got accepted %0d occ %0d rdy %0b want 4 4 0", k, occ0, s_if0.ready);
        end
        guard = 0;
        while ((k < 5 || mq.size() != 0) && guard < 30) begin
            cycle(k < 5, 64'hA0 + 64'(k), 1'b1, 1'b1, p, q, b);
            if (p) k++;
            if (q) got.push_back(b);
            guard++;
        end
        checks++;
        if (got.size() != 5) begin
            errors++; $display("FAIL drain_count: got %0d want 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i].data !== 64'hA0 + 64'(i)) begin
                    errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, got[i].data, 64'hA0 + 64'(i));
                end
            end
        end
    endtask

    task automatic test_full_pop();
        bit p, q; beat_t b;
        cur_saf = 1'b0;
        do_reset(1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0, p, q, b);
        cycle(1'b1, 64'h200, 1'b1, 1'b1, p, q, b);
        checks++;
        if (occ0 !== 3'd3) begin errors++; $display("FAIL full_pop occ: got %0d want 3", occ0); end
        for (int i = 0; i < 6; i++) cycle(1'b1, 64'h300 + 64'(i), 1'b1, 1'b1, p, q, b);
        checks++;
        if (occ0 !== 3'd3) begin errors++; $display("FAIL steady occ: got %0d want 3", occ0); end
    endtask

    task automatic test_saf_packet();
        beat_t beats[$]; beat_t got[$];
        cur_saf = 1'b1;
        do_reset(1);
        for (int i = 0; i < 3; i++) beats.push_back('{last: (i == 2), data: 64'hB0 + 64'(i)});
        run_stream(beats, 1, got);
        beats = {};
        for (int i = 0; i < 6; i++) beats.push_back('{last: (i == 5), data: 64'hC0 + 64'(i)});
        run_stream(beats, 1, got);
    endtask

    task automatic test_reset_mid_burst();
        bit p, q; beat_t b;
        cur_saf = 1'b0;
        do_reset(1);
        cycle(1'b0, '0, 1'b0, 1'b0, p, q, b);
        cycle(1'b1, 64'hD0, 1'b0, 1'b0, p, q, b);
        cycle(1'b1, 64'hD1, 1'b0, 1'b0, p, q, b);
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, p, q, b);
    endtask

    task automatic test_random();
        beat_t beats[$]; beat_t got[$];
        for (int m = 0; m < 2; m++) begin
            cur_saf = (m == 1);
            do_reset(1);
            beats = {};
            for (int i = 0; i < 120; i++) begin
                beats.push_back('{last: ($urandom_range(0, 3) == 0) || (i == 119),
                                  data: {$urandom, $urandom}});
            end
            run_stream(beats, 2, got);
        end
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_fill_drain();
        test_full_pop();
        test_saf_packet();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
